// File: rtl/cpu_ram_responder.sv
// RAM-side responder for the cpu_ram_if bus: fixed-latency byte/half/word loads and stores
// against an on-chip word array, with alignment, width and range checking at accept.
module cpu_ram_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned LATENCY      = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned LDST_WIDTH_W = 2
) (
  input  logic                    ram_clk,
  input  logic                    nrst,
  input  logic [31:0]             ram_addr,
  input  logic [31:0]             ram_store,
  input  logic                    ram_ren,
  input  logic                    ram_wen,
  input  logic [LDST_WIDTH_W-1:0] ram_width,
  output logic [31:0]             ram_load,
  output logic [1:0]              ram_state
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;
  localparam logic [CW-1:0] CntInit = CW'(LATENCY - 1);

  localparam logic [LDST_WIDTH_W-1:0] LdstByte = LDST_WIDTH_W'(0);
  localparam logic [LDST_WIDTH_W-1:0] LdstHalf = LDST_WIDTH_W'(1);
  localparam logic [LDST_WIDTH_W-1:0] LdstWord = LDST_WIDTH_W'(2);

  // State codes double as the ram_state_t encoding (FREE/BUSY/DONE/ERROR).
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;
  localparam logic [1:0] StErr  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             store_q, store_d;
  logic [LDST_WIDTH_W-1:0] width_q, width_d;
  logic                    is_load_q, is_load_d;
  logic [31:0]             load_q, load_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic                    in_idle;
  logic [31:0]             req_addr;
  logic [31:0]             req_store;
  logic [LDST_WIDTH_W-1:0] req_width;
  logic                    req_is_load;
  logic [31:0]             offset;
  logic                    in_range;
  logic                    bad_width;
  logic                    misaligned;
  logic                    req_err;
  logic [AW-1:0]           word_idx;
  logic                    commit;
  logic [3:0]              wr_be;
  logic [31:0]             wr_data;
  logic [31:0]             rd_word;
  logic [31:0]             rd_lane;
  logic                    unused_offset_lsbs;

  // In IDLE the live bus is the request; afterwards the latched copy is.
  always_comb begin
    in_idle     = (state_q == StIdle);
    req_addr    = in_idle ? ram_addr  : addr_q;
    req_store   = in_idle ? ram_store : store_q;
    req_width   = in_idle ? ram_width : width_q;
    req_is_load = in_idle ? ram_ren   : is_load_q;
  end

  assign offset             = req_addr - BASE_ADDR;
  assign in_range           = ({1'b0, offset} < SpanBytes);
  assign word_idx           = offset[AW+1:2];
  assign unused_offset_lsbs = ^offset[1:0];

  always_comb begin
    bad_width  = 1'b0;
    misaligned = 1'b0;
    unique case (ram_width)
      LdstByte: misaligned = 1'b0;
      LdstHalf: misaligned = ram_addr[0];
      LdstWord: misaligned = |ram_addr[1:0];
      default:  bad_width  = 1'b1;
    endcase
    req_err = (ram_ren & ram_wen) | bad_width | misaligned | ~in_range;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    store_d   = store_q;
    width_d   = width_q;
    is_load_d = is_load_q;
    case (state_q)
      StIdle: begin
        if (ram_ren | ram_wen) begin
          if (req_err) begin
            state_d = StErr;
          end else begin
            addr_d    = ram_addr;
            store_d   = ram_store;
            width_d   = ram_width;
            is_load_d = ram_ren;
            if (LATENCY <= 1) begin
              state_d = StDone;
              cnt_d   = '0;
            end else begin
              state_d = StBusy;
              cnt_d   = CntInit;
            end
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The access happens on the edge that enters DONE; nrst gating keeps a store
  // from landing while reset is held.
  assign commit = nrst & (state_d == StDone) & (state_q != StDone);

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = req_store;
    unique case (req_width)
      LdstByte: begin
        wr_be   = 4'b0001 << req_addr[1:0];
        wr_data = {4{req_store[7:0]}};
      end
      LdstHalf: begin
        wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_store[15:0]}};
      end
      LdstWord: begin
        wr_be   = 4'b1111;
        wr_data = req_store;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = req_store;
      end
    endcase
  end

  always_comb begin
    rd_word = mem[word_idx];
    rd_lane = 32'h0;
    unique case (req_width)
      LdstByte: rd_lane = (rd_word >> {req_addr[1:0], 3'b000}) & 32'h0000_00ff;
      LdstHalf: rd_lane = {16'h0000, req_addr[1] ? rd_word[31:16] : rd_word[15:0]};
      LdstWord: rd_lane = rd_word;
      default:  rd_lane = 32'h0;
    endcase
    load_d = (commit & req_is_load) ? rd_lane : load_q;
  end

  always_ff @(posedge ram_clk) begin
    if (commit && !req_is_load) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge ram_clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= 32'h0;
      store_q   <= 32'h0;
      width_q   <= '0;
      is_load_q <= 1'b0;
      load_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      width_q   <= width_d;
      is_load_q <= is_load_d;
      load_q    <= load_d;
    end
  end

  assign ram_state = state_q;
  assign ram_load  = load_q;

  done_one_cycle: assert property (@(posedge ram_clk) disable iff (!nrst)
    (state_q == StDone) |=> (state_q == StIdle));
  err_one_cycle: assert property (@(posedge ram_clk) disable iff (!nrst)
    (state_q == StErr) |=> (state_q == StIdle));

endmodule
